// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for opcode_sequencer and microcode_mod.
//   - sequencer state encoding
//   - CB prefix byte, interrupt-dispatch pseudo-opcode, idle opcode
//   - opcode width shared with the microcode ROM address
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 9;
  localparam int STEP_W   = 3;

  localparam logic [7:0]          CB_PREFIX  = 8'hCB;
  // 0xD3 is an unused LR35902 slot, so it can never collide with a fetched opcode.
  localparam logic [OPCODE_W-1:0] IRQ_OPCODE = 9'h0D3;
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 9'h000;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_CB_FETCH = 2'd1,
    S_EXEC     = 2'd2,
    S_HALT     = 2'd3
  } state_t;

endpackage

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: front end of the CPU control path.
// Fetches instruction bytes, folds the 0xCB prefix into opcode bit 8, holds the
// 9-bit microcode opcode stable while the instruction executes, injects the
// interrupt-dispatch pseudo-opcode and parks the core in HALT.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous reset, active low
//   mem_rdata    in   fetched instruction byte
//   mem_valid    in   mem_rdata valid this cycle
//   instr_done   in   last cycle of the current instruction (EXEC only)
//   halt_req     in   current instruction is HALT (sampled with instr_done)
//   ime          in   interrupt master enable
//   irq_pending  in   any enabled interrupt pending
//   fetch_req    out  request next byte (combinational)
//   opcode       out  {cb_page, byte}, registered
//   opcode_valid out  state is EXEC
//   step         out  cycles elapsed in EXEC, saturating
//   irq_ack      out  one-cycle pulse when the dispatch is injected
//   halted       out  state is HALT
module opcode_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_valid,
  input  logic                instr_done,
  input  logic                halt_req,
  input  logic                ime,
  input  logic                irq_pending,
  output logic                fetch_req,
  output logic [OPCODE_W-1:0] opcode,
  output logic                opcode_valid,
  output logic [STEP_W-1:0]   step,
  output logic                irq_ack,
  output logic                halted
);

  state_t              state_q;
  logic [OPCODE_W-1:0] opcode_q;
  logic [STEP_W-1:0]   step_q;
  logic                irq_take;

  // The reset state is FETCH, so the fetch/ack decode is gated with reset_n to
  // keep both outputs low while reset is held.
  assign irq_take = reset_n & (state_q == S_FETCH) & ime & irq_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      opcode_q <= NOP_OPCODE;
      step_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // Interrupt wins over a coincident byte; that byte is dropped.
          if (irq_take) begin
            opcode_q <= IRQ_OPCODE;
            state_q  <= S_EXEC;
          end else if (mem_valid) begin
            if (mem_rdata == CB_PREFIX) begin
              state_q <= S_CB_FETCH;
            end else begin
              opcode_q <= {1'b0, mem_rdata};
              state_q  <= S_EXEC;
            end
          end
        end
        S_CB_FETCH: begin
          // Any byte here, including another 0xCB, is a CB-page opcode.
          if (mem_valid) begin
            opcode_q <= {1'b1, mem_rdata};
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (instr_done) begin
            step_q   <= '0;
            // Back to the idle opcode so FETCH and HALT present NOP.
            opcode_q <= NOP_OPCODE;
            state_q  <= halt_req ? S_HALT : S_FETCH;
          end else if (step_q != '1) begin
            step_q <= step_q + 1'b1;
          end
        end
        S_HALT: begin
          // Wake on any pending interrupt; FETCH decides whether to dispatch.
          if (irq_pending) begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign fetch_req    = reset_n & (((state_q == S_FETCH) & ~irq_take) |
                                   (state_q == S_CB_FETCH));
  assign irq_ack      = irq_take;
  assign opcode       = opcode_q;
  assign opcode_valid = (state_q == S_EXEC);
  assign step         = step_q;
  assign halted       = (state_q == S_HALT);

endmodule
